veririsc_controller: RTL and testbench
======================================

# veririsc_controller

Instruction-sequencing controller for the VeriRISC CPU. Steps an 8-phase machine per instruction and decodes phase, the current opcode and the ALU zero flag into the control strobes. These strobes drive the program counter (load/enable side), instruction register, accumulator, memory and address mux. It is the driving end of the program counter's `load`/`enab` interface: `ld_pc` feeds the counter's load and `inc_pc` feeds its enable.

## Interface
Parameters:
- OP_WIDTH, 3, opcode width (fixed ISA: 8 opcodes).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- enab  input  1  run enable; phase advances only when 1.
- opcode  input  OP_WIDTH  opcode field from instruction register.
- zero  input  1  accumulator-zero flag.
- phase  output  3  current phase (debug/trace).
- sel  output  1  address mux: 1 = PC address, 0 = IR operand address.
- rd  output  1  memory read enable.
- ld_ir  output  1  instruction-register load strobe.
- inc_pc  output  1  PC increment strobe (to counter enab).
- ld_pc  output  1  PC load strobe (to counter load).
- ld_ac  output  1  accumulator load strobe.
- wr  output  1  memory write strobe.
- data_e  output  1  accumulator-to-data-bus drive enable.
- halt  output  1  processor halted.

## Operation
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = ADD|AND|XOR|LDA.
- Phases, in order (0..7): INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE; STORE wraps to INST_ADDR.
- Extra state HALTED: not part of the 0..7 sequence; `phase` reports 7 while in HALTED.
- Decode (all others 0):
  - INST_ADDR: sel.
  - INST_FETCH: sel, rd.
  - INST_LOAD: sel, rd, ld_ir.
  - IDLE: sel, rd, ld_ir.
  - OP_ADDR: inc_pc = (opcode!=HLT); halt = (opcode==HLT).
  - OP_FETCH: rd = ALUOP.
  - ALU_OP: rd = ALUOP; inc_pc = (SKZ && zero); ld_pc = JMP; data_e = STO.
  - STORE: rd = ALUOP; ld_ac = ALUOP; ld_pc = JMP; wr = STO; data_e = STO.
- HLT: leaving OP_ADDR with opcode==HLT and enab=1 enters HALTED.
  - HALTED: halt=1, all other outputs 0.
  - HALTED is exited only by reset.
- Enable gating:
  - enab=0: phase and HALTED hold.
  - The write/advance strobes (ld_ir, inc_pc, ld_pc, ld_ac, wr) are ANDed with enab, so a stalled phase never double-increments or double-writes.
  - sel, rd, data_e and halt are not gated.
- opcode and zero are sampled combinationally each cycle. The controller does not latch them; IR contents are stable from IDLE onward.

## Timing
- Reset (rst=0, async): phase=INST_ADDR, HALTED cleared.
  - Outputs during and after reset: sel=1, all others 0, phase=0.
  - Reset mid-instruction abandons it; the first rising edge with rst=1 and enab=1 moves to INST_FETCH.
- One phase per enabled clock; full instruction = 8 enabled cycles.
- Outputs are combinational from registered state plus opcode/zero/enab, with no added latency. A strobe asserted in phase P takes effect at the clock edge that leaves P.
- Reset-release edge: a rising edge coincident with rst deassertion is not guaranteed to advance.
- SKZ with zero=0: no ALU_OP increment. JMP: ld_pc is asserted in both ALU_OP and STORE (idempotent reload).
- enab falling in any phase: state frozen; the next enabled edge resumes from the same phase.

## Structure
- Shared package veririsc_pkg:
  - opcode constants (HLT..JMP) and OP_WIDTH;
  - phase encoding constants (INST_ADDR..STORE).
- The counter, ALU, register and memory blocks reuse veririsc_pkg.
- No sub-module:
  - single always block for the 3-bit phase register plus halted flag (async active-low reset);
  - single combinational decode block.

## Test plan
- Reset: rst=0 for 2 cycles → phase=0, sel=1, rd/ld_ir/inc_pc/ld_pc/ld_ac/wr/data_e/halt=0; release and 8 enabled clocks → phase sequence 0..7 then 0.
- ADD (opcode=2): rd=1 in phases 1,2,3,5,6,7; ld_ir in 2,3; inc_pc only in 4; ld_ac only in 7; wr=data_e=0 throughout.
- STO (opcode=6): data_e=1 in phases 6,7; wr=1 only in 7; rd=0 in 5,6,7; inc_pc in 4.
- SKZ (opcode=1):
  - zero=1 → inc_pc in phases 4 and 6 (two PC increments per instruction);
  - zero=0 → inc_pc only in 4.
- JMP (opcode=7): ld_pc=1 in phases 6,7, inc_pc=1 only in 4. HLT (opcode=0): halt=1 in phase 4, inc_pc=0; the next state is HALTED, with halt=1 and other outputs 0 for 20 cycles; rst=0 → phase=0, halt=0.
- enab=0 held 3 cycles in OP_ADDR (ADD): phase stays 4 and inc_pc=0 while stalled; enab=1 → exactly one inc_pc cycle, then phase=5. Async rst=0 asserted mid-phase 5 → outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/veririsc_pkg.sv
// Shared VeriRISC definitions: opcode constants, ISA width and the controller phase encoding.
package veririsc_pkg;

    localparam int unsigned OP_WIDTH = 3;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    // Opcodes that read an operand from memory and load the accumulator.
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/veririsc_controller.sv
// VeriRISC instruction-sequencing controller: 8-phase sequencer plus halted flag, with
// combinational decode of phase/opcode/zero into the datapath control strobes.
module veririsc_controller #(
    parameter int unsigned OP_WIDTH = veririsc_pkg::OP_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enab,
    input  logic [OP_WIDTH-1:0] opcode,
    input  logic                zero,
    output logic [2:0]          phase,
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                inc_pc,
    output logic                ld_pc,
    output logic                ld_ac,
    output logic                wr,
    output logic                data_e,
    output logic                halt
);
    import veririsc_pkg::*;

    phase_e     phase_q, phase_d;
    logic       halted_q, halted_d;
    logic [2:0] phase_inc;
    logic       op_hlt, op_skz, op_sto, op_jmp, op_alu;

    assign op_hlt = (opcode == OP_WIDTH'(HLT));
    assign op_skz = (opcode == OP_WIDTH'(SKZ));
    assign op_sto = (opcode == OP_WIDTH'(STO));
    assign op_jmp = (opcode == OP_WIDTH'(JMP));
    assign op_alu = is_aluop(3'(opcode));

    assign phase_inc = phase_q + 3'd1;

    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (enab && !halted_q) begin
            // Parking phase at STORE lets the phase output read 7 while halted.
            if (phase_q == OP_ADDR && op_hlt) begin
                halted_d = 1'b1;
                phase_d  = STORE;
            end else begin
                phase_d = phase_e'(phase_inc);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    assign phase = phase_q;

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            // Write/advance strobes are gated by enab so a stalled phase acts only once.
            unique case (phase_q)
                INST_ADDR: sel = 1'b1;
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = enab;
                end
                OP_ADDR: begin
                    inc_pc = enab && !op_hlt;
                    halt   = op_hlt;
                end
                OP_FETCH: rd = op_alu;
                ALU_OP: begin
                    rd     = op_alu;
                    inc_pc = enab && op_skz && zero;
                    ld_pc  = enab && op_jmp;
                    data_e = op_sto;
                end
                STORE: begin
                    rd     = op_alu;
                    ld_ac  = enab && op_alu;
                    ld_pc  = enab && op_jmp;
                    wr     = enab && op_sto;
                    data_e = op_sto;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_veririsc_controller.sv
// Bench for veririsc_controller: directed instruction scenarios plus random traffic, checked
// against a per-phase strobe-mask reference model.
module tb_veririsc_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enab = 1'b0;
    logic       zero = 1'b0;
    logic [2:0] opcode = 3'd0;

    logic [2:0] phase;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;

    int total = 0;
    int bad   = 0;

    int m_phase  = 0;
    bit m_halted = 1'b0;

    veririsc_controller #(.OP_WIDTH(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .enab   (enab),
        .opcode (opcode),
        .zero   (zero),
        .phase  (phase),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .data_e (data_e),
        .halt   (halt)
    );

    always #5 clk = ~clk;

    // Expected {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}; each strobe is
    // an 8-bit mask of the phases where it is active for the given opcode.
    function automatic logic [11:0] model_out(input int ph, input bit hlt, input bit en,
                                              input logic [2:0] op, input bit z);
        bit         alu, sto, jmp, skz;
        logic [7:0] g, m_sel, m_rd, m_ir, m_inc, m_ldpc, m_ac, m_wr, m_de, m_halt;
        logic [2:0] ph3;
        if (hlt) return {3'd7, 8'h00, 1'b1};
        alu    = (op >= 3'd2) && (op <= 3'd5);
        sto    = (op == 3'd6);
        jmp    = (op == 3'd7);
        skz    = (op == 3'd1);
        g      = en ? 8'hFF : 8'h00;
        m_sel  = 8'h0F;
        m_rd   = 8'h0E | (alu ? 8'hE0 : 8'h00);
        m_ir   = 8'h0C & g;
        m_inc  = (((op != 3'd0) ? 8'h10 : 8'h00) | ((skz && z) ? 8'h40 : 8'h00)) & g;
        m_ldpc = (jmp ? 8'hC0 : 8'h00) & g;
        m_ac   = (alu ? 8'h80 : 8'h00) & g;
        m_wr   = (sto ? 8'h80 : 8'h00) & g;
        m_de   = sto ? 8'hC0 : 8'h00;
        m_halt = (op == 3'd0) ? 8'h10 : 8'h00;
        ph3    = 3'(ph);
        return {ph3, m_sel[ph3], m_rd[ph3], m_ir[ph3], m_inc[ph3], m_ldpc[ph3], m_ac[ph3],
                m_wr[ph3], m_de[ph3], m_halt[ph3]};
    endfunction

    task automatic check(input string tag);
        logic [11:0] obs, exp;
        if (!rst) begin
            m_phase  = 0;
            m_halted = 1'b0;
        end
        exp = model_out(m_phase, m_halted, enab, opcode, zero);
        obs = {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%03h expected=%03h (model phase=%0d halted=%0d)",
                   tag, obs, exp, m_phase, m_halted);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            m_phase  = 0;
            m_halted = 1'b0;
        end else if (enab && !m_halted) begin
            if (m_phase == 4 && opcode == 3'd0) m_halted = 1'b1;
            else m_phase = (m_phase + 1) % 8;
        end
        #1;
    endtask

    task automatic apply(input bit en, input logic [2:0] op, input bit z, input string tag);
        enab   = en;
        opcode = op;
        zero   = z;
        #3;
        check(tag);
        tick();
    endtask

    task automatic run_instr(input logic [2:0] op, input bit z, input string tag);
        for (int i = 0; i < 8; i++) apply(1'b1, op, z, tag);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset held for two cycles, then released away from any edge.
        apply(1'b1, 3'd2, 1'b0, "reset0");
        apply(1'b1, 3'd2, 1'b0, "reset1");
        rst = 1'b1;

        run_instr(3'd2, 1'b0, "add");
        apply(1'b0, 3'd2, 1'b0, "wrap_to_0");
        run_instr(3'd6, 1'b0, "sto");
        run_instr(3'd1, 1'b1, "skz_z1");
        run_instr(3'd1, 1'b0, "skz_z0");
        run_instr(3'd7, 1'b1, "jmp");
        run_instr(3'd3, 1'b0, "and");
        run_instr(3'd5, 1'b1, "lda");

        // ADD stalled three cycles in OP_ADDR, then async reset in OP_FETCH.
        for (int i = 0; i < 4; i++) apply(1'b1, 3'd2, 1'b0, "stall_pre");
        for (int i = 0; i < 3; i++) apply(1'b0, 3'd2, 1'b0, "stall_hold");
        apply(1'b1, 3'd2, 1'b0, "stall_release");
        enab = 1'b1;
        #3;
        check("phase5");
        rst = 1'b0;
        #1;
        check("async_reset");
        tick();
        apply(1'b1, 3'd2, 1'b0, "reset_hold");
        rst = 1'b1;

        // HLT: halt in OP_ADDR, then stuck in HALTED until reset.
        for (int i = 0; i < 5; i++) apply(1'b1, 3'd0, 1'b0, "hlt");
        for (int i = 0; i < 20; i++)
            apply(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), "halted");
        rst = 1'b0;
        apply(1'b1, 3'd0, 1'b0, "halt_reset");
        rst = 1'b1;

        // Random traffic with occasional stalls; reset out of HALTED now and then.
        for (int i = 0; i < 600; i++) begin
            if (m_halted && $urandom_range(0, 7) == 0) rst = 1'b0;
            apply(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), "random");
            rst = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
